// File: rtl/mem_pkg.sv
// Shared FSM state type and abort data pattern for the RAM arbiter.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_e;

  localparam logic [31:0] ABORT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between an instruction-fetch port and a data port.
// Define MEM_ARB_TIMEOUT_EN to abort grants that stay busy for WAIT_LIMIT cycles.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int WAIT_LIMIT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_store,
  input  logic [DATA_W-1:0] ram_load,
  input  logic              ram_busy,
  output logic              err
);

  localparam logic [DATA_W-1:0] ABORT_WORD = DATA_W'(ABORT_DATA);

  arb_state_e        state_q;
  logic              prev_d_q;
  logic              ram_ren_q;
  logic              ram_wen_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_store_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              i_ready_q;
  logic              d_ready_q;

  logic              d_req;
  logic              take_i;
  logic              timeout;

  assign d_req  = d_read | d_write;
  // Data normally wins; a fetch waiting behind a data grant gets the next slot.
  assign take_i = i_req & (~d_req | prev_d_q);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  // Fires in the WAIT_LIMIT-th consecutive busy cycle of a grant.
  assign timeout = (state_q != IDLE) && ram_busy && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst || state_q == IDLE) begin
      cnt_q <= '0;
    end else if (ram_busy) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (timeout) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic [31:0] unused_wait_limit;

  assign unused_wait_limit = 32'(WAIT_LIMIT);
  assign timeout           = 1'b0;
  assign err               = 1'b0;
`endif

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order inside the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      prev_d_q    <= 1'b0;
      ram_ren_q   <= 1'b0;
      ram_wen_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_store_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
    end else begin
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (take_i) begin
            state_q     <= GRANT_I;
            prev_d_q    <= 1'b0;
            ram_ren_q   <= 1'b1;
            ram_wen_q   <= 1'b0;
            ram_addr_q  <= i_addr;
            ram_store_q <= '0;
          end else if (d_req) begin
            state_q     <= GRANT_D;
            prev_d_q    <= 1'b1;
            ram_ren_q   <= ~d_write;
            ram_wen_q   <= d_write;
            ram_addr_q  <= d_addr;
            ram_store_q <= d_wdata;
          end
        end
        GRANT_I, GRANT_D: begin
          if (!ram_busy || timeout) begin
            state_q   <= IDLE;
            ram_ren_q <= 1'b0;
            ram_wen_q <= 1'b0;
            if (state_q == GRANT_I) begin
              i_ready_q <= 1'b1;
              i_rdata_q <= timeout ? ABORT_WORD : ram_load;
            end else begin
              d_ready_q <= 1'b1;
              if (timeout) begin
                d_rdata_q <= ABORT_WORD;
              end else if (ram_ren_q) begin
                d_rdata_q <= ram_load;
              end
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          ram_ren_q <= 1'b0;
          ram_wen_q <= 1'b0;
        end
      endcase
    end
  end

  assign i_rdata   = i_rdata_q;
  assign i_ready   = i_ready_q;
  assign d_rdata   = d_rdata_q;
  assign d_ready   = d_ready_q;
  assign ram_ren   = ram_ren_q;
  assign ram_wen   = ram_wen_q;
  assign ram_addr  = ram_addr_q;
  assign ram_store = ram_store_q;

endmodule
